// File: rtl/sram_fifo_pkg.sv
// Shared defaults and helpers for the SRAM-backed FIFO controller.
package sram_fifo_pkg;

  localparam int unsigned DEFAULT_BITS       = 32;
  localparam int unsigned DEFAULT_WORD_DEPTH = 384;
  localparam int unsigned DEFAULT_ADDR_WIDTH = 9;
  localparam int unsigned MASK_W             = DEFAULT_BITS / 8;

  // Depth need not be a power of two, so wrap explicitly at depth-1.
  function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/sram_fifo_outbuf.sv
// Two-entry output buffer absorbing the macro's registered read latency.
module sram_fifo_outbuf
  import sram_fifo_pkg::*;
#(
  parameter int unsigned BITS = DEFAULT_BITS
) (
  input  logic            sys_clk,
  input  logic            sys_rst,
  input  logic            cap,
  input  logic [BITS-1:0] cap_data,
  input  logic            pop,
  output logic            out_valid,
  output logic [BITS-1:0] out_data,
  output logic [1:0]      ob_cnt
);

  logic [BITS-1:0] ent0, ent1;

  assign out_valid = (ob_cnt != 2'd0);
  assign out_data  = ent0;

  // ent0 is always the head; a pop shifts ent1 forward.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      ob_cnt <= '0;
      ent0   <= '0;
      ent1   <= '0;
    end else begin
      case ({cap, pop})
        2'b10: begin
          if (ob_cnt == 2'd0) ent0 <= cap_data;
          else                ent1 <= cap_data;
          ob_cnt <= ob_cnt + 2'd1;
        end
        2'b01: begin
          ent0   <= ent1;
          ob_cnt <= ob_cnt - 2'd1;
        end
        2'b11: begin
          if (ob_cnt == 2'd2) begin
            ent0 <= ent1;
            ent1 <= cap_data;
          end else begin
            ent0 <= cap_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/sram_fifo_ctrl.sv
// FIFO controller driving a 1rw1r fakeram macro: writes via rw0, reads via r0.
module sram_fifo_ctrl
  import sram_fifo_pkg::*;
#(
  parameter int unsigned BITS       = DEFAULT_BITS,
  parameter int unsigned WORD_DEPTH = DEFAULT_WORD_DEPTH,
  parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BITS-1:0]       in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [BITS-1:0]       out_data,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  ram_rw0_ce,
  output logic                  ram_rw0_we,
  output logic [ADDR_WIDTH-1:0] ram_rw0_addr,
  output logic [BITS-1:0]       ram_rw0_wd,
  output logic [BITS/8-1:0]     ram_rw0_wmask,
  input  logic [BITS-1:0]       ram_rw0_rd,
  output logic                  ram_r0_ce,
  output logic [ADDR_WIDTH-1:0] ram_r0_addr,
  input  logic [BITS-1:0]       ram_r0_rd
);

  localparam int unsigned         LW    = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH:0] DEPTH = LW'(WORD_DEPTH);

  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [ADDR_WIDTH:0]   mem_cnt;
  logic                  inflight;
  logic [1:0]            ob_cnt;
  logic [1:0]            occ;
  logic                  push, pop, issue;
  logic                  unused_rw0_rd;

  assign unused_rw0_rd = ^ram_rw0_rd;

  assign in_ready = !sys_rst && (level < DEPTH);
  assign push     = in_valid & in_ready;
  assign pop      = out_valid & out_ready;

  // A read may be issued into a full pipeline when a pop frees a slot this cycle.
  assign occ   = ob_cnt + {1'b0, inflight};
  assign issue = (mem_cnt != '0) && ((occ < 2'd2) || ((occ == 2'd2) && pop));

  assign ram_rw0_ce    = push;
  assign ram_rw0_we    = push;
  assign ram_rw0_addr  = wr_ptr;
  assign ram_rw0_wd    = in_data;
  assign ram_rw0_wmask = '1;
  assign ram_r0_ce     = issue;
  assign ram_r0_addr   = rd_ptr;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      mem_cnt  <= '0;
      inflight <= 1'b0;
      level    <= '0;
    end else begin
      if (push) wr_ptr <= ADDR_WIDTH'(ptr_inc(32'(wr_ptr), WORD_DEPTH));
      if (issue) rd_ptr <= ADDR_WIDTH'(ptr_inc(32'(rd_ptr), WORD_DEPTH));
      if (push && !issue)      mem_cnt <= mem_cnt + LW'(1);
      else if (!push && issue) mem_cnt <= mem_cnt - LW'(1);
      inflight <= issue;
      // Tracks mem_cnt + inflight + ob_cnt; internal moves cancel out.
      if (push && !pop)      level <= level + LW'(1);
      else if (!push && pop) level <= level - LW'(1);
    end
  end

  sram_fifo_outbuf #(.BITS(BITS)) u_outbuf (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .cap       (inflight),
    .cap_data  (ram_r0_rd),
    .pop       (pop),
    .out_valid (out_valid),
    .out_data  (out_data),
    .ob_cnt    (ob_cnt)
  );

endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// Self-checking bench for sram_fifo_ctrl with a behavioural 1rw1r RAM model.
module tb_sram_fifo_ctrl;

  localparam int unsigned BITS  = 32;
  localparam int unsigned DEPTH = 384;
  localparam int unsigned AW    = 9;

  logic            sys_clk = 1'b0;
  logic            sys_rst = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [BITS-1:0] in_data = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [BITS-1:0] out_data;
  logic [AW:0]     level;
  logic            ram_rw0_ce, ram_rw0_we;
  logic [AW-1:0]   ram_rw0_addr;
  logic [BITS-1:0] ram_rw0_wd;
  logic [BITS/8-1:0] ram_rw0_wmask;
  logic [BITS-1:0] ram_rw0_rd = '0;
  logic            ram_r0_ce;
  logic [AW-1:0]   ram_r0_addr;
  logic [BITS-1:0] ram_r0_rd = '0;

  int errors = 0;
  int checks = 0;
  logic [BITS-1:0] sb[$];
  logic [BITS-1:0] ram [0:511];
  int prev_wr_addr = -1;
  int wraps = 0;

  always #5 sys_clk = ~sys_clk;

  sram_fifo_ctrl #(.BITS(BITS), .WORD_DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .level(level),
    .ram_rw0_ce(ram_rw0_ce), .ram_rw0_we(ram_rw0_we), .ram_rw0_addr(ram_rw0_addr),
    .ram_rw0_wd(ram_rw0_wd), .ram_rw0_wmask(ram_rw0_wmask), .ram_rw0_rd(ram_rw0_rd),
    .ram_r0_ce(ram_r0_ce), .ram_r0_addr(ram_r0_addr), .ram_r0_rd(ram_r0_rd)
  );

  // Macro model: synchronous write, registered read.
  always @(posedge sys_clk) begin
    if (ram_rw0_ce && ram_rw0_we) ram[ram_rw0_addr] <= ram_rw0_wd;
    if (ram_r0_ce) ram_r0_rd <= ram[ram_r0_addr];
  end

  // Scoreboard and address monitor, sampled mid-cycle.
  always @(negedge sys_clk) begin
    if (!sys_rst) begin
      if (out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL pop_underflow: got %h, none expected", out_data);
        end else begin
          logic [BITS-1:0] exp;
          exp = sb.pop_front();
          if (out_data !== exp) begin
            errors++;
            $display("FAIL pop_data: got %h, expected %h", out_data, exp);
          end
        end
      end
      if (in_valid && in_ready) sb.push_back(in_data);
      if (ram_rw0_ce) begin
        checks++;
        if (int'(ram_rw0_addr) >= DEPTH) begin
          errors++;
          $display("FAIL wr_addr_range: got %0d, required < %0d", ram_rw0_addr, DEPTH);
        end
        if (prev_wr_addr == DEPTH - 1 && ram_rw0_addr == '0) wraps++;
        prev_wr_addr = int'(ram_rw0_addr);
      end
      if (ram_r0_ce) begin
        checks++;
        if (int'(ram_r0_addr) >= DEPTH || (ram_rw0_ce && ram_rw0_addr == ram_r0_addr)) begin
          errors++;
          $display("FAIL rd_addr: got %0d (wr %0d ce %0b)", ram_r0_addr, ram_rw0_addr, ram_rw0_ce);
        end
      end
    end
  end

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic drain();
    int guard = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (level != '0 && guard < 2000) begin
      step();
      guard++;
    end
    out_ready = 1'b0;
    checks++;
    if (level != '0 || sb.size() != 0) begin
      errors++;
      $display("FAIL drain: level %0d queue %0d, expected 0 and 0", level, sb.size());
    end
  endtask

  task automatic test_reset();
    sys_rst = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL reset_in_ready_low: got %b, expected 0", in_ready);
    end
    repeat (2) @(posedge sys_clk);
    @(negedge sys_clk) sys_rst = 1'b0;
    step();
    checks++;
    if ({ram_rw0_ce, ram_rw0_we, ram_r0_ce} !== 3'b000 || level !== '0 ||
        in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: ce/we/rce=%b%b%b level=%0d in_ready=%b out_valid=%b, expected 000 0 1 0",
               ram_rw0_ce, ram_rw0_we, ram_r0_ce, level, in_ready, out_valid);
    end
  endtask

  task automatic test_single();
    in_valid = 1'b1;
    in_data  = 32'hDEADBEEF;
    @(negedge sys_clk);
    checks++;
    if (ram_rw0_ce !== 1'b1 || ram_rw0_we !== 1'b1 || ram_rw0_addr !== '0 ||
        ram_rw0_wmask !== 4'hF || ram_rw0_wd !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL single_write: ce=%b we=%b addr=%0d mask=%h wd=%h, expected 1 1 0 f deadbeef",
               ram_rw0_ce, ram_rw0_we, ram_rw0_addr, ram_rw0_wmask, ram_rw0_wd);
    end
    step();
    in_valid = 1'b0;
    @(negedge sys_clk);
    checks++;
    if (ram_r0_ce !== 1'b1 || ram_r0_addr !== '0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_issue: rce=%b raddr=%0d out_valid=%b, expected 1 0 0",
               ram_r0_ce, ram_r0_addr, out_valid);
    end
    step();
    @(negedge sys_clk);
    checks++;
    if (out_valid !== 1'b0 || ram_r0_ce !== 1'b0 || level !== 10'd1) begin
      errors++;
      $display("FAIL single_inflight: out_valid=%b rce=%b level=%0d, expected 0 0 1",
               out_valid, ram_r0_ce, level);
    end
    step();
    @(negedge sys_clk);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'hDEADBEEF || level !== 10'd1) begin
      errors++;
      $display("FAIL single_out: out_valid=%b data=%h level=%0d, expected 1 deadbeef 1",
               out_valid, out_data, level);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    @(negedge sys_clk);
    checks++;
    if (out_valid !== 1'b0 || level !== '0) begin
      errors++;
      $display("FAIL single_pop: out_valid=%b level=%0d, expected 0 0", out_valid, level);
    end
  endtask

  task automatic test_fill();
    int n = 0;
    int guard = 0;
    logic acc;
    out_ready = 1'b0;
    while (n < int'(DEPTH) && guard < 2000) begin
      in_valid = 1'b1;
      in_data  = BITS'(n);
      acc = in_ready;
      step();
      if (acc) n++;
      guard++;
    end
    in_valid = 1'b0;
    @(negedge sys_clk);
    checks++;
    if (n != int'(DEPTH) || level !== 10'(DEPTH) || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL fill_full: pushed %0d level %0d in_ready %b, expected 384 384 0", n, level, in_ready);
    end
    step();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = 32'd999;
      @(negedge sys_clk);
      checks++;
      if (in_ready !== 1'b0 || ram_rw0_ce !== 1'b0) begin
        errors++;
        $display("FAIL fill_refuse: in_ready=%b wce=%b, expected 0 0", in_ready, ram_rw0_ce);
      end
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge sys_clk);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL full_no_passthrough: in_ready=%b, expected 0", in_ready);
    end
    step();
    out_ready = 1'b0;
    @(negedge sys_clk);
    checks++;
    if (in_ready !== 1'b1 || level !== 10'(DEPTH - 1)) begin
      errors++;
      $display("FAIL full_pop_ready: in_ready=%b level=%0d, expected 1 383", in_ready, level);
    end
    step();
    drain();
  endtask

  task automatic test_wrap();
    int n = 0;
    int guard = 0;
    logic acc;
    wraps = 0;
    while (n < 500 && guard < 5000) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = $urandom;
      out_ready = $urandom_range(0, 1) == 1;
      acc = in_valid & in_ready;
      step();
      if (acc) n++;
      guard++;
    end
    drain();
    checks++;
    if (n != 500 || wraps < 1) begin
      errors++;
      $display("FAIL wrap: pushed %0d wraps %0d, expected 500 and >=1", n, wraps);
    end
  endtask

  task automatic test_backpressure();
    int issues = 0;
    logic [BITS-1:0] held = '0;
    logic have = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 13; i++) begin
      in_valid = (i < 10);
      in_data  = 32'hA500_0000 + BITS'(i);
      @(negedge sys_clk);
      if (ram_r0_ce) issues++;
      if (out_valid) begin
        if (have) begin
          checks++;
          if (out_data !== held) begin
            errors++; $display("FAIL bp_hold: data %h, expected %h", out_data, held);
          end
        end else begin
          held = out_data;
          have = 1'b1;
        end
      end
      step();
    end
    in_valid = 1'b0;
    checks++;
    if (issues != 2 || level !== 10'd10 || !have || held !== 32'hA500_0000) begin
      errors++;
      $display("FAIL bp_issue: issues %0d level %0d head %h, expected 2 10 a5000000", issues, level, held);
    end
    drain();
  endtask

  task automatic test_stream();
    int pops = 0;
    int first = -1;
    int maxlvl = 0;
    for (int i = 0; i < 1000; i++) begin
      in_valid  = 1'b1;
      out_ready = 1'b1;
      in_data   = $urandom;
      @(negedge sys_clk);
      if (out_valid) begin
        pops++;
        if (first < 0) first = i;
      end
      if (int'(level) > maxlvl) maxlvl = int'(level);
      step();
    end
    drain();
    checks++;
    if (first != 3 || pops != 997 || maxlvl > 3) begin
      errors++;
      $display("FAIL stream: first %0d pops %0d maxlvl %0d, expected 3 997 <=3", first, pops, maxlvl);
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 32'hC0DE_0000 + BITS'(i);
      step();
    end
    in_valid = 1'b0;
    step();
    checks++;
    if (out_valid !== 1'b1 || level !== 10'd5) begin
      errors++; $display("FAIL mid_pre: out_valid=%b level=%0d, expected 1 5", out_valid, level);
    end
    #2 sys_rst = 1'b1;
    #1;
    sb.delete();
    checks++;
    if (out_valid !== 1'b0 || level !== '0 || in_ready !== 1'b0 || ram_r0_ce !== 1'b0) begin
      errors++;
      $display("FAIL mid_async: out_valid=%b level=%0d in_ready=%b rce=%b, expected 0 0 0 0",
               out_valid, level, in_ready, ram_r0_ce);
    end
    @(negedge sys_clk) sys_rst = 1'b0;
    step();
    step();
    checks++;
    if (out_valid !== 1'b0 || level !== '0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_after: out_valid=%b level=%0d in_ready=%b, expected 0 0 1", out_valid, level, in_ready);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_wrap();
    test_backpressure();
    test_stream();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
